// File: rtl/ysyx_22051013_trap_ctrl_pkg.sv
// ============================================================================
// ysyx_22051013_trap_ctrl_pkg : shared types and constants for the trap controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_22051013_trap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_T_SAVE = 3'd1,
    ST_T_JUMP = 3'd2,
    ST_R_EXEC = 3'd3,
    ST_R_JUMP = 3'd4
  } trap_state_e;

  localparam logic [63:0] ECALL_CAUSE_DEF = 64'd11;
  localparam logic [63:0] TIMER_CAUSE_DEF = 64'h8000_0000_0000_0007;

  // Bit positions of the CSR file control nibble
  localparam int CSR_CTL_WR    = 3;
  localparam int CSR_CTL_RD    = 2;
  localparam int CSR_CTL_ECALL = 1;
  localparam int CSR_CTL_MRET  = 0;

  function automatic logic [3:0] pack_csr_ctl(input logic ecall_ena, input logic mret_ena);
    logic [3:0] ctl;
    ctl                = 4'b0000;
    ctl[CSR_CTL_ECALL] = ecall_ena;
    ctl[CSR_CTL_MRET]  = mret_ena;
    return ctl;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22051013_trap_ctrl.sv
// ============================================================================
// ysyx_22051013_trap_ctrl : M-mode trap entry (ecall, timer irq) / mret sequencer
// Timer interrupt arbitration enabled by YSYX_22051013_TRAP_IRQ_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22051013_trap_ctrl
  import ysyx_22051013_trap_ctrl_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] ECALL_CAUSE = ECALL_CAUSE_DEF[XLEN-1:0],
  parameter logic [XLEN-1:0] TIMER_CAUSE = TIMER_CAUSE_DEF[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ecall_req,
  input  logic            mret_req,
  input  logic [XLEN-1:0] cur_pc,
  input  logic            irq_timer,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            ecall_ena,
  output logic            mret_ena,
  output logic [XLEN-1:0] mcause_value,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  trap_state_e     state;
  trap_state_e     next_state;
  logic            cap_en;
  logic [XLEN-1:0] cap_cause;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] cause;
  logic            unused_inputs;

  // Low mtvec bits carry the vector mode, which this core does not support
  assign unused_inputs = ^{mtvec[1:0], irq_timer, mstatus_mie, TIMER_CAUSE};

  always_comb begin
    next_state = state;
    cap_en     = 1'b0;
    cap_cause  = ECALL_CAUSE;
    case (state)
      ST_IDLE: begin
        if (ecall_req) begin
          cap_en     = 1'b1;
          next_state = ST_T_SAVE;
        end else if (mret_req) begin
          next_state = ST_R_EXEC;
        end
`ifdef YSYX_22051013_TRAP_IRQ_EN
        else if (irq_timer && mstatus_mie) begin
          cap_en     = 1'b1;
          cap_cause  = TIMER_CAUSE;
          next_state = ST_T_SAVE;
        end
`endif
      end
      ST_T_SAVE: next_state = ST_T_JUMP;
      ST_T_JUMP: next_state = ST_IDLE;
      ST_R_EXEC: next_state = ST_R_JUMP;
      ST_R_JUMP: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      epc            <= '0;
      cause          <= '0;
      ecall_ena      <= 1'b0;
      mret_ena       <= 1'b0;
      stall          <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      state          <= next_state;
      if (cap_en) begin
        epc   <= cur_pc;
        cause <= cap_cause;
      end
      ecall_ena      <= (next_state == ST_T_SAVE);
      mret_ena       <= (next_state == ST_R_EXEC);
      stall          <= (next_state != ST_IDLE);
      busy           <= (next_state != ST_IDLE);
      redirect_valid <= (next_state == ST_T_JUMP) || (next_state == ST_R_JUMP);
    end
  end

  // Data outputs follow the state register; the jump targets use this cycle's CSR values
  always_comb begin
    mcause_value = '0;
    csr_wdata    = '0;
    redirect_pc  = '0;
    case (state)
      ST_T_SAVE: begin
        mcause_value = cause;
        csr_wdata    = epc;
      end
      ST_T_JUMP: redirect_pc = {mtvec[XLEN-1:2], 2'b00};
      ST_R_JUMP: redirect_pc = mepc;
      default:   redirect_pc = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22051013_trap_ctrl.sv
// ============================================================================
// tb_ysyx_22051013_trap_ctrl : self-checking bench for the trap controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22051013_trap_ctrl;

  localparam logic [63:0] C_ECALL = 64'd11;
  localparam logic [63:0] C_TIMER = 64'h8000_0000_0000_0007;
`ifdef YSYX_22051013_TRAP_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ecall_req, mret_req, irq_timer, mstatus_mie;
  logic [63:0] cur_pc, mtvec, mepc;
  logic        ecall_ena, mret_ena, stall, redirect_valid, busy;
  logic [63:0] mcause_value, csr_wdata, redirect_pc;

  ysyx_22051013_trap_ctrl dut (
    .clk(clk), .rst(rst), .ecall_req(ecall_req), .mret_req(mret_req),
    .cur_pc(cur_pc), .irq_timer(irq_timer), .mstatus_mie(mstatus_mie),
    .mtvec(mtvec), .mepc(mepc), .ecall_ena(ecall_ena), .mret_ena(mret_ena),
    .mcause_value(mcause_value), .csr_wdata(csr_wdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: an accepted request occupies the next two cycles (strobe, then redirect)
  int          cycles_left = 0;
  bit          is_trap     = 1'b0;
  logic [63:0] m_epc       = '0;
  logic [63:0] m_cause     = '0;
  bit          chk_en      = 1'b0;
  int          n_strobes   = 0;

  task automatic step(input logic r, input logic e, input logic m, input logic it,
                      input logic mi, input logic [63:0] pc, input logic [63:0] tv,
                      input logic [63:0] ep);
    logic [63:0] x_pc;
    @(negedge clk);
    rst = r; ecall_req = e; mret_req = m; irq_timer = it; mstatus_mie = mi;
    cur_pc = pc; mtvec = tv; mepc = ep;
    #1;
    if (chk_en) begin
      x_pc = '0;
      if (cycles_left == 1) x_pc = is_trap ? {tv[63:2], 2'b00} : ep;
      check("ecall_ena", 64'(ecall_ena), 64'(cycles_left == 2 && is_trap));
      check("mret_ena", 64'(mret_ena), 64'(cycles_left == 2 && !is_trap));
      check("mcause_value", mcause_value, (cycles_left == 2 && is_trap) ? m_cause : 64'd0);
      check("csr_wdata", csr_wdata, (cycles_left == 2 && is_trap) ? m_epc : 64'd0);
      check("stall", 64'(stall), 64'(cycles_left > 0));
      check("busy", 64'(busy), 64'(cycles_left > 0));
      check("redirect_valid", 64'(redirect_valid), 64'(cycles_left == 1));
      check("redirect_pc", redirect_pc, x_pc);
      if (ecall_ena || mret_ena) n_strobes++;
    end
    if (r) cycles_left = 0;
    else if (cycles_left > 0) cycles_left--;
    else if (e) begin
      cycles_left = 2; is_trap = 1'b1; m_epc = pc; m_cause = C_ECALL;
    end else if (m) begin
      cycles_left = 2; is_trap = 1'b0;
    end else if (IRQ_EN && it && mi) begin
      cycles_left = 2; is_trap = 1'b1; m_epc = pc; m_cause = C_TIMER;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h8000_1001, 64'h0);
  endtask

  int accepts;

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    chk_en = 1'b1;
    idle(1);
    check("reset_busy", 64'(busy), 64'd0);

    // ecall sequence with literal expectations
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0010, 64'h8000_1001, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h8000_1001, 64'h0);
    check("ec_n1_ena", 64'(ecall_ena), 64'd1);
    check("ec_n1_wdata", csr_wdata, 64'h8000_0010);
    check("ec_n1_cause", mcause_value, 64'd11);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h8000_1001, 64'h0);
    check("ec_n2_pc", redirect_pc, 64'h8000_1000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h8000_1001, 64'h0);
    check("ec_n3_busy", 64'(busy), 64'd0);

    // mret sequence
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h8000_0014);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h8000_0014);
    check("mr_n1_ena", 64'(mret_ena), 64'd1);
    check("mr_n1_stall", 64'(stall), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h8000_0014);
    check("mr_n2_pc", redirect_pc, 64'h8000_0014);
    check("mr_n2_stall", 64'(stall), 64'd1);
    idle(1);

    // timer interrupt with mie set
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0100, 64'h8000_1000, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h8000_1000, 64'h0);
    check("irq_ena", 64'(ecall_ena), IRQ_EN ? 64'd1 : 64'd0);
    check("irq_cause", mcause_value, IRQ_EN ? C_TIMER : 64'd0);
    check("irq_wdata", csr_wdata, IRQ_EN ? 64'h8000_0100 : 64'd0);
    idle(3);

    // masked interrupt: nothing may happen for 20 cycles
    n_strobes = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0200, 64'h8000_1000, 64'h0);
    check("masked_strobes", 64'(n_strobes), 64'd0);
    check("masked_stall", 64'(stall), 64'd0);

    // ecall and irq together: ecall first, irq re-taken on return if still pending
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h8000_0300, 64'h8000_1000, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0, 64'h8000_1000, 64'h0);
    check("prio_cause", mcause_value, C_ECALL);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0, 64'h8000_1000, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0304, 64'h8000_1000, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h8000_1000, 64'h0);
    check("prio_irq_cause", mcause_value, IRQ_EN ? C_TIMER : 64'd0);
    idle(3);

    // reset while in T_SAVE, then a fresh ecall
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0400, 64'h8000_2000, 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h8000_2000, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h8000_2000, 64'h0);
    check("rst_redirect", 64'(redirect_valid), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0500, 64'h8000_2000, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h8000_2000, 64'h0);
    check("post_rst_wdata", csr_wdata, 64'h8000_0500);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h8000_2000, 64'h0);
    check("post_rst_pc", redirect_pc, 64'h8000_2000);
    idle(1);

    // randomized traffic against the reference
    accepts = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cycles_left == 0 && !(($urandom_range(99) < 2))) accepts++;
      step(($urandom_range(99) < 2), ($urandom_range(99) < 15), ($urandom_range(99) < 15),
           ($urandom_range(99) < 30), ($urandom_range(99) < 50),
           {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22051013_trap_ctrl.md
Name: ysyx_22051013_trap_ctrl

Overview:
- Sequences machine-mode trap entry (ecall, timer interrupt) and trap return (mret) for the single-cycle core.
- Sits between decode/exec and the CSR file. Drives the CSR ecall/mret strobes, the mcause value and the write data.
- Stalls the PC and regfile while the sequence runs, then issues a one-cycle PC redirect to mtvec or mepc.

Parameters:
- XLEN, 64, data/PC width.
- ECALL_CAUSE, 64'd11, mcause value for environment call from M-mode.
- TIMER_CAUSE, 64'h8000_0000_0000_0007, mcause value for the machine timer interrupt.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ecall_req  in  1  decoded ecall this cycle
- mret_req  in  1  decoded mret this cycle
- cur_pc  in  XLEN  PC of the instruction in exec
- irq_timer  in  1  timer interrupt pending, level
- mstatus_mie  in  1  global interrupt enable from the CSR file
- mtvec  in  XLEN  current mtvec from the CSR file
- mepc  in  XLEN  current mepc from the CSR file
- ecall_ena  out  1  CSR trap-entry strobe (mepc/mcause/mstatus update)
- mret_ena  out  1  CSR trap-return strobe
- mcause_value  out  XLEN  cause written on ecall_ena
- csr_wdata  out  XLEN  epc written on ecall_ena
- stall  out  1  freeze PC and regfile write
- redirect_valid  out  1  PC override this cycle
- redirect_pc  out  XLEN  new PC
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: every output is 0; state is IDLE; the internal epc and cause registers are 0.
- States: IDLE, T_SAVE, T_JUMP, R_EXEC, R_JUMP.
- IDLE arbitration, fixed priority:
  - ecall_req wins first: capture epc = cur_pc, cause = ECALL_CAUSE, go to T_SAVE.
  - else mret_req: go to R_EXEC.
  - else irq_timer && mstatus_mie: capture epc = cur_pc, cause = TIMER_CAUSE, go to T_SAVE.
  - else stay in IDLE.
- Outputs are registered and depend on state only.
- T_SAVE:
  - ecall_ena=1, csr_wdata=epc, mcause_value=cause, stall=1.
  - Always goes to T_JUMP.
- T_JUMP:
  - redirect_valid=1, redirect_pc={mtvec[63:2],2'b00}, stall=1.
  - Uses mtvec as sampled this cycle, so a CSR write that lands in T_SAVE is visible.
  - Goes to IDLE.
- R_EXEC:
  - mret_ena=1, stall=1.
  - Always goes to R_JUMP.
- R_JUMP:
  - redirect_valid=1, redirect_pc=mepc, stall=1.
  - Goes to IDLE.
- Latency: request accepted at cycle N; strobe at N+1; redirect at N+2; back in IDLE at N+3.
- Exactly one strobe pulse per accepted request.
- Requests arriving while busy are ignored; the core is stalled and must re-present them.
- Interrupts are never accepted outside IDLE, nor in the cycle an ecall or mret is present.
- irq_timer is level-sensitive: if it is still high and mie=1 when the FSM returns to IDLE, it is taken again.
- ecall_ena and mret_ena are never both high.
- Reset in any state: return to IDLE next edge, all outputs 0, any in-flight strobe or redirect suppressed.

Optional Feature:
- YSYX_22051013_TRAP_IRQ_EN
- Defined: timer interrupt arbitration is present as above.
- Undefined: irq_timer and mstatus_mie are ignored, and TIMER_CAUSE is never emitted. The FSM handles ecall and mret only.

Decomposition:
- Shared package: state encoding enum; ECALL_CAUSE/TIMER_CAUSE constants; the csr_ctl bit-index constants (wr=3, rd=2, ecall=1, mret=0) so the top level can pack {0,0,ecall_ena,mret_ena}.
- No sub-module: a single FSM plus two capture registers.

Test Plan:
- ecall_req at cur_pc=0x8000_0010, mtvec=0x8000_1001:
  - N+1: ecall_ena=1, csr_wdata=0x8000_0010, mcause_value=11.
  - N+2: redirect_pc=0x8000_1000.
  - N+3: busy=0.
- mret_req with mepc=0x8000_0014: N+1 mret_ena=1; N+2 redirect_pc=0x8000_0014; stall high for N+1..N+2.
- irq_timer=1, mstatus_mie=1 at cur_pc=0x8000_0100:
  - Enable defined: mcause_value=0x8000_0000_0000_0007, csr_wdata=0x8000_0100.
  - Enable undefined: no strobe.
- irq_timer=1, mstatus_mie=0 for 20 cycles -> no strobe, no stall.
- ecall_req and irq_timer (mie=1) in the same cycle -> mcause_value=11; the interrupt is taken only after return to IDLE.
- rst asserted during T_SAVE -> next edge all outputs 0, no redirect; a fresh ecall afterwards completes normally.
